// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and whoever drives it.
// The master starts scans and feeds y_in; the controller returns sel/data/valid/busy.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] data;
  logic       valid;
  logic       busy;

  modport master (
    output start, cont, abort, y_in,
    input  sel, data, valid, busy
  );

  modport slave (
    input  start, cont, abort, y_in,
    output sel, data, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux channel by channel, settling SETTLE cycles per channel,
// and publishes the assembled 4-bit word with a one-cycle valid strobe.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // With no settle time a channel goes straight to its sample cycle.
  localparam logic [2:0] CNT_LAST   = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);
  localparam state_t     SCAN_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state_q, state_d;
  logic [1:0] sel_q,   sel_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [3:0] shift_q, shift_d;
  logic [3:0] data_q,  data_d;
  logic       valid_q, valid_d;
  logic       busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 3'd0;
      shift_q <= 4'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        sel_d = 2'd0;
        cnt_d = 3'd0;
        if (bus.start) state_d = SCAN_ENTRY;
      end

      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          sel_d   = 2'd0;
          cnt_d   = 3'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          sel_d   = 2'd0;
          cnt_d   = 3'd0;
        end else begin
          shift_d[sel_q] = bus.y_in;
          cnt_d          = 3'd0;
          if (sel_q == 2'd3) begin
            // Last channel bypasses the shift register so data sees it this edge.
            state_d = S_DONE;
            sel_d   = 2'd0;
            data_d  = {bus.y_in, shift_q[2:0]};
          end else begin
            state_d = SCAN_ENTRY;
            sel_d   = sel_q + 2'd1;
          end
        end
      end

      S_DONE: begin
        sel_d = 2'd0;
        cnt_d = 3'd0;
        if (bus.abort)     state_d = S_IDLE;
        else if (bus.cont) state_d = SCAN_ENTRY;
        else               state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 2'd0;
        cnt_d   = 3'd0;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: three controllers (SETTLE = 1, 0, 7), each feeding from a 4:1 mux model.
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] i1, i0, i7;

  always #5 clk = ~clk;

  mux_scan_ctrl_if if1 ();
  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if7 ();

  assign if1.y_in = i1[if1.sel];
  assign if0.y_in = i0[if0.sel];
  assign if7.y_in = i7[if7.sel];

  mux_scan_ctrl #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux_scan_ctrl #(.SETTLE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_scan_ctrl #(.SETTLE(7)) u7 (.clk(clk), .rst_n(rst_n), .bus(if7));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i1 = 4'd0; i0 = 4'd0; i7 = 4'd0;
    if1.start = 0; if1.cont = 0; if1.abort = 0;
    if0.start = 0; if0.cont = 0; if0.abort = 0;
    if7.start = 0; if7.cont = 0; if7.abort = 0;

    // reset state
    #3;
    chk("rst_sel1",   if1.sel,   0);
    chk("rst_data1",  if1.data,  0);
    chk("rst_valid1", if1.valid, 0);
    chk("rst_busy1",  if1.busy,  0);
    chk("rst_busy0",  if0.busy,  0);
    chk("rst_busy7",  if7.busy,  0);
    #9 rst_n = 1'b1;
    tick();

    // scan pattern, SETTLE=1
    i1 = 4'b1010;
    if1.start = 1;
    tick();
    if1.start = 0;
    chk("s1_sel_e0",  if1.sel,  0);
    chk("s1_busy_e0", if1.busy, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("s1_sel_e%0d", k),   if1.sel,   k / 2);
      chk($sformatf("s1_valid_e%0d", k), if1.valid, 0);
    end
    tick();
    chk("s1_valid_e8", if1.valid, 1);
    chk("s1_data_e8",  if1.data,  4'b1010);
    chk("s1_sel_e8",   if1.sel,   0);
    tick();
    chk("s1_valid_e9", if1.valid, 0);
    chk("s1_busy_e9",  if1.busy,  0);
    chk("s1_data_e9",  if1.data,  4'b1010);

    // start while busy is ignored
    i1 = 4'b0101;
    if1.start = 1;
    tick();
    if1.start = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) if1.start = 1;
      if (k == 5) if1.start = 0;
      tick();
      chk($sformatf("sb_valid_e%0d", k), if1.valid, (k == 8) ? 1 : 0);
      if (k == 4) chk("sb_sel_e4", if1.sel, 2);
      if (k == 8) chk("sb_data_e8", if1.data, 4'b0101);
    end
    chk("sb_busy_end", if1.busy, 0);

    // abort at sel==2 after data=1111
    i1 = 4'b1111;
    if1.start = 1;
    tick();
    if1.start = 0;
    for (int k = 1; k <= 9; k++) tick();
    chk("ab_pre_data", if1.data, 4'b1111);
    i1 = 4'b0000;
    if1.start = 1;
    tick();
    if1.start = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("ab_sel_e4", if1.sel, 2);
    if1.abort = 1;
    tick();
    if1.abort = 0;
    chk("ab_busy", if1.busy,  0);
    chk("ab_sel",  if1.sel,   0);
    chk("ab_data", if1.data,  4'b1111);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("ab_valid_%0d", k), if1.valid, 0);
    end
    chk("ab_data_end", if1.data, 4'b1111);

    // asynchronous reset mid-scan at sel==1
    i1 = 4'b1111;
    if1.start = 1;
    tick();
    if1.start = 0;
    tick();
    tick();
    chk("rm_sel_pre", if1.sel, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_sel",   if1.sel,   0);
    chk("rm_data",  if1.data,  0);
    chk("rm_busy",  if1.busy,  0);
    chk("rm_valid", if1.valid, 0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("rm_valid_%0d", k), if1.valid, 0);
      chk($sformatf("rm_busy_%0d", k),  if1.busy,  0);
    end

    // SETTLE=0, continuous mode
    i0 = 4'b0110;
    if0.cont  = 1;
    if0.start = 1;
    tick();
    if0.start = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("c0_valid_e%0d", k), if0.valid, (k == 4 || k == 9) ? 1 : 0);
      if (k == 4) begin
        chk("c0_data_first", if0.data, 4'b0110);
        i0 = 4'b1001;
      end
    end
    chk("c0_data_second", if0.data, 4'b1001);
    if0.cont = 0;
    tick();
    chk("c0_valid_e10", if0.valid, 0);
    chk("c0_busy_e10",  if0.busy,  0);

    // boundary SETTLE=7
    i7 = 4'b1100;
    if7.start = 1;
    tick();
    if7.start = 0;
    chk("s7_sel_e0", if7.sel, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("s7_valid_e%0d", k), if7.valid, (k == 32) ? 1 : 0);
      if (k < 32) chk($sformatf("s7_sel_e%0d", k), if7.sel, k / 8);
    end
    chk("s7_data", if7.data, 4'b1100);
    tick();
    chk("s7_busy_end", if7.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
